// File: rtl/mem_stage_mc.sv
// mem_stage_mc: multi-cycle MEM pipeline stage with request/ready data-memory handshake.
//
// Sits between the X/M and M/W pipeline registers. ALU-only bundles pass through
// in one cycle; loads/stores are captured into holding registers and issued to a
// variable-latency memory, stalling upstream until mem_ready. The M/W bundle is
// registered here. A retired halt bundle parks the stage in HALT until reset.
//
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that stay BUSY for
// TIMEOUT cycles (sticky mem_err, load data forced to all ones, RegWrite killed).
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid .. in_halt             X/M bundle from the previous stage
//   stall                           upstream must hold its X/M contents
//   mem_req/we/addr/wdata           registered request to data memory
//   mem_ready, mem_rdata            memory completion and read data
//   out_valid .. out_halt           registered M/W bundle
//   halted                          sticky, a halt bundle has retired
//   mem_err                         sticky, an access was aborted by timeout
module mem_stage_mc #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_wr_reg,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic              in_halt,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_mdata,
    output logic [REG_W-1:0]  out_wr_reg,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic              out_halt,
    output logic              halted,
    output logic              mem_err
);
    typedef enum logic [1:0] {IDLE, BUSY, HALT} state_t;

    state_t            r_state;
    logic              r_req;
    logic [DATA_W-1:0] r_h_addr;
    logic [DATA_W-1:0] r_h_wdata;
    logic [REG_W-1:0]  r_h_wr_reg;
    logic              r_h_we;
    logic              r_h_rd;
    logic              r_h_reg_write;
    logic              r_h_mem_to_reg;
    logic              r_h_halt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_alu;
    logic [DATA_W-1:0] r_out_mdata;
    logic [REG_W-1:0]  r_out_wr_reg;
    logic              r_out_reg_write;
    logic              r_out_mem_to_reg;
    logic              r_out_halt;
    logic              r_halted;
    logic              w_mem_op;
    logic              w_to;
    logic              w_fin;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    // Abort at the end of the TIMEOUT-th BUSY cycle; a same-cycle ready wins.
    assign w_to    = !mem_ready && r_cnt == CNT_W'(TIMEOUT - 1);
    assign mem_err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_to    = 1'b0;
    assign mem_err = 1'b0;
`endif

    assign w_mem_op = in_mem_read | in_mem_write;
    assign w_fin    = r_state == BUSY && (mem_ready || w_to);
    // Upstream advances in the cycle the outstanding access retires.
    assign stall    = r_state == HALT || (r_state == BUSY && !w_fin) ||
                      (r_state == IDLE && in_valid && w_mem_op);

    assign mem_req        = r_req;
    assign mem_we         = r_h_we;
    assign mem_addr       = r_h_addr;
    assign mem_wdata      = r_h_wdata;
    assign out_valid      = r_out_valid;
    assign out_alu        = r_out_alu;
    assign out_mdata      = r_out_mdata;
    assign out_wr_reg     = r_out_wr_reg;
    assign out_reg_write  = r_out_reg_write;
    assign out_mem_to_reg = r_out_mem_to_reg;
    assign out_halt       = r_out_halt;
    assign halted         = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_req            <= 1'b0;
            r_h_addr         <= '0;
            r_h_wdata        <= '0;
            r_h_wr_reg       <= '0;
            r_h_we           <= 1'b0;
            r_h_rd           <= 1'b0;
            r_h_reg_write    <= 1'b0;
            r_h_mem_to_reg   <= 1'b0;
            r_h_halt         <= 1'b0;
            r_out_valid      <= 1'b0;
            r_out_alu        <= '0;
            r_out_mdata      <= '0;
            r_out_wr_reg     <= '0;
            r_out_reg_write  <= 1'b0;
            r_out_mem_to_reg <= 1'b0;
            r_out_halt       <= 1'b0;
            r_halted         <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt            <= '0;
            r_err            <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: if (in_valid) begin
                    if (w_mem_op) begin
                        r_h_addr       <= in_addr;
                        r_h_wdata      <= in_wdata;
                        r_h_wr_reg     <= in_wr_reg;
                        r_h_we         <= in_mem_write;
                        // Read+write together is treated as a write.
                        r_h_rd         <= in_mem_read & ~in_mem_write;
                        r_h_reg_write  <= in_reg_write;
                        r_h_mem_to_reg <= in_mem_to_reg;
                        r_h_halt       <= in_halt;
                        r_req          <= 1'b1;
                        r_state        <= BUSY;
`ifdef MEM_TIMEOUT_EN
                        r_cnt          <= '0;
`endif
                    end else begin
                        r_out_valid      <= 1'b1;
                        r_out_alu        <= in_addr;
                        r_out_mdata      <= '0;
                        r_out_wr_reg     <= in_wr_reg;
                        r_out_reg_write  <= in_reg_write;
                        r_out_mem_to_reg <= in_mem_to_reg;
                        r_out_halt       <= in_halt;
                        r_halted         <= in_halt;
                        r_state          <= in_halt ? HALT : IDLE;
                    end
                end
                BUSY: if (w_fin) begin
                    r_out_valid      <= 1'b1;
                    r_out_alu        <= r_h_addr;
                    // Without mem_ready this is a timeout abort.
                    r_out_mdata      <= !mem_ready ? '1 : r_h_rd ? mem_rdata : '0;
                    r_out_wr_reg     <= r_h_wr_reg;
                    r_out_reg_write  <= r_h_reg_write & mem_ready;
                    r_out_mem_to_reg <= r_h_mem_to_reg;
                    r_out_halt       <= r_h_halt;
                    r_halted         <= r_h_halt;
                    r_req            <= 1'b0;
                    r_state          <= r_h_halt ? HALT : IDLE;
`ifdef MEM_TIMEOUT_EN
                    r_err            <= r_err | ~mem_ready;
                end else begin
                    r_cnt            <= r_cnt + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
